// File: rtl/tomasulo_pkg.sv
// -----------------------------------------------------------------------------
// tomasulo_pkg
// Shared definitions for the Tomasulo core front end.
//   - opcode constants OP_NOP / OP_ADD / OP_SUB / OP_MUL / OP_DIV
//   - unit_t: which reservation-station class an opcode targets
//   - classify(): opcode -> unit_t; unknown opcodes behave as NOP
//   - inst_t: instruction record {op_type, dest, src1, src2} at INST_W bits
// Modules that carry records at a parameterised width W pack the same
// four fields, in the same order, into a flat 4*W vector.
// -----------------------------------------------------------------------------
package tomasulo_pkg;

    localparam int unsigned INST_W = 8;

    localparam int unsigned OP_NOP = 0;
    localparam int unsigned OP_ADD = 1;
    localparam int unsigned OP_SUB = 2;
    localparam int unsigned OP_MUL = 3;
    localparam int unsigned OP_DIV = 4;

    typedef enum logic [1:0] {
        UNIT_NONE = 2'd0,
        UNIT_ADD  = 2'd1,
        UNIT_MUL  = 2'd2
    } unit_t;

    typedef struct packed {
        logic [INST_W-1:0] op_type;
        logic [INST_W-1:0] dest;
        logic [INST_W-1:0] src1;
        logic [INST_W-1:0] src2;
    } inst_t;

    function automatic unit_t classify(input logic [31:0] op);
        unit_t u;
        case (op)
            OP_ADD, OP_SUB: u = UNIT_ADD;
            OP_MUL, OP_DIV: u = UNIT_MUL;
            default:        u = UNIT_NONE;
        endcase
        return u;
    endfunction

endpackage

// File: rtl/issue_queue.sv
// -----------------------------------------------------------------------------
// issue_queue
// Circular instruction buffer: up to two records written per cycle at the
// tail, zero/one/two records popped per cycle at the head.
// Ports:
//   clk, rst        clock, asynchronous active-high reset (empties queue)
//   i_push          write i_rec0 at the tail
//   i_push2         also write i_rec1 behind it (only with i_push)
//   i_rec0, i_rec1  records {type, dest, src1, src2}, 4*W bits each
//   i_pop           number of records removed from the head (0..2)
//   o_h0, o_h1      oldest and next-oldest records (valid per o_count)
//   o_count         occupancy, log2(QDEPTH)+1 bits
// -----------------------------------------------------------------------------
module issue_queue #(
    parameter  int QDEPTH = 4,
    parameter  int W      = 8,
    localparam int AW     = $clog2(QDEPTH),
    localparam int CW     = AW + 1,
    localparam int RW     = 4 * W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic          i_push2,
    input  logic [RW-1:0] i_rec0,
    input  logic [RW-1:0] i_rec1,
    input  logic [1:0]    i_pop,
    output logic [RW-1:0] o_h0,
    output logic [RW-1:0] o_h1,
    output logic [CW-1:0] o_count
);

    logic [RW-1:0] r_mem [QDEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic [1:0]    w_push_n;

    assign w_push_n = i_push ? (i_push2 ? 2'd2 : 2'd1) : 2'd0;

    // Pointers are AW bits wide, so the power-of-two depth gives the
    // modulo-QDEPTH wrap for free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + AW'(i_pop);
            r_tail  <= r_tail + AW'(w_push_n);
            r_count <= r_count + CW'(w_push_n) - CW'(i_pop);
        end
    end

    // Storage needs no reset: occupancy alone says which slots are live.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_tail] <= i_rec0;
            if (i_push2) begin
                r_mem[r_tail + AW'(1)] <= i_rec1;
            end
        end
    end

    assign o_h0    = r_mem[r_head];
    assign o_h1    = r_mem[r_head + AW'(1)];
    assign o_count = r_count;

endmodule

// File: rtl/issue_scheduler.sv
// -----------------------------------------------------------------------------
// issue_scheduler
// In-order dual-issue dispatch from the decode unit to the adder and
// multiplier reservation stations, gated by per-unit credits and the
// AR_Status / MR_Status hold flags.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid / in_ready      decoded pair handshake
//   inst2_valid              second instruction of the pair is real
//   inst1_*, inst2_*         instruction fields (type, dest, src1, src2)
//   AR_Status, MR_Status     1 = station class holds, no issue to it
//   add_free, mul_free       one station entry released (credit return)
//   add_issue_*, mul_issue_* registered one-cycle issue pulse + payload
//   select_instruction       bit0/bit1 = head 0/1 dequeued last cycle
// Optional (macro ISSUE_STATS_EN):
//   stall_cycles             cycles with a non-empty queue and no dequeue
//   issued_count             non-NOP instructions issued (wrapping)
// Handshake: a pair transfers on a rising edge where in_valid && in_ready.
// in_ready depends only on current occupancy (at least two free slots), never
// on same-cycle dequeues; the decoder holds its pair until it sees in_ready.
// -----------------------------------------------------------------------------
module issue_scheduler #(
    parameter int QDEPTH = 4,
    parameter int ADD_RS = 3,
    parameter int MUL_RS = 2,
    parameter int W      = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         inst2_valid,
    input  logic [W-1:0] inst1_type,
    input  logic [W-1:0] inst1_dest,
    input  logic [W-1:0] inst1_src1,
    input  logic [W-1:0] inst1_src2,
    input  logic [W-1:0] inst2_type,
    input  logic [W-1:0] inst2_dest,
    input  logic [W-1:0] inst2_src1,
    input  logic [W-1:0] inst2_src2,
    input  logic         AR_Status,
    input  logic         MR_Status,
    input  logic         add_free,
    input  logic         mul_free,
    output logic         add_issue_valid,
    output logic [W-1:0] add_issue_type,
    output logic [W-1:0] add_issue_dest,
    output logic [W-1:0] add_issue_src1,
    output logic [W-1:0] add_issue_src2,
    output logic         mul_issue_valid,
    output logic [W-1:0] mul_issue_type,
    output logic [W-1:0] mul_issue_dest,
    output logic [W-1:0] mul_issue_src1,
    output logic [W-1:0] mul_issue_src2,
    output logic [1:0]   select_instruction
`ifdef ISSUE_STATS_EN
    ,
    output logic [15:0]  stall_cycles,
    output logic [15:0]  issued_count
`endif
);

    import tomasulo_pkg::*;

    localparam int AW  = $clog2(QDEPTH);
    localparam int CW  = AW + 1;
    localparam int RW  = 4 * W;
    localparam int ACW = $clog2(ADD_RS + 1);
    localparam int MCW = $clog2(MUL_RS + 1);

    logic [RW-1:0]  w_rec0, w_rec1, w_h0, w_h1;
    logic [CW-1:0]  w_count;
    logic           w_push;
    logic [1:0]     w_pop;
    unit_t          w_u0, w_u1;
    logic           w_ok0, w_ok1, w_go0, w_go1;
    logic           w_add_iss, w_mul_iss, w_add_inc, w_mul_inc;
    logic [RW-1:0]  w_add_rec, w_mul_rec;
    logic [ACW-1:0] r_add_cred;
    logic [MCW-1:0] r_mul_cred;

    assign w_rec0   = {inst1_type, inst1_dest, inst1_src1, inst1_src2};
    assign w_rec1   = {inst2_type, inst2_dest, inst2_src1, inst2_src2};
    assign in_ready = (CW'(QDEPTH) - w_count) >= CW'(2);
    assign w_push   = in_valid && in_ready;

    issue_queue #(.QDEPTH(QDEPTH), .W(W)) u_queue (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_push2 (inst2_valid),
        .i_rec0  (w_rec0),
        .i_rec1  (w_rec1),
        .i_pop   (w_pop),
        .o_h0    (w_h0),
        .o_h1    (w_h1),
        .o_count (w_count)
    );

    assign w_u0 = classify(32'(w_h0[RW-1 -: W]));
    assign w_u1 = classify(32'(w_h1[RW-1 -: W]));

    // A head may leave if it is a NOP or its unit has credit and is not held.
    always_comb begin
        w_ok0 = 1'b0;
        w_ok1 = 1'b0;
        case (w_u0)
            UNIT_NONE: w_ok0 = 1'b1;
            UNIT_ADD:  w_ok0 = (r_add_cred != '0) && !AR_Status;
            UNIT_MUL:  w_ok0 = (r_mul_cred != '0) && !MR_Status;
            default:   w_ok0 = 1'b0;
        endcase
        case (w_u1)
            UNIT_NONE: w_ok1 = 1'b1;
            UNIT_ADD:  w_ok1 = (r_add_cred != '0) && !AR_Status;
            UNIT_MUL:  w_ok1 = (r_mul_cred != '0) && !MR_Status;
            default:   w_ok1 = 1'b0;
        endcase
    end

    // h1 only follows h0, and never into the unit h0 already used this cycle.
    assign w_go0 = (w_count != '0) && w_ok0;
    assign w_go1 = w_go0 && (w_count >= CW'(2)) && w_ok1 &&
                   ((w_u1 == UNIT_NONE) || (w_u1 != w_u0));
    assign w_pop = w_go1 ? 2'd2 : (w_go0 ? 2'd1 : 2'd0);

    assign w_add_iss = (w_go0 && w_u0 == UNIT_ADD) || (w_go1 && w_u1 == UNIT_ADD);
    assign w_mul_iss = (w_go0 && w_u0 == UNIT_MUL) || (w_go1 && w_u1 == UNIT_MUL);
    assign w_add_rec = (w_go0 && w_u0 == UNIT_ADD) ? w_h0 : w_h1;
    assign w_mul_rec = (w_go0 && w_u0 == UNIT_MUL) ? w_h0 : w_h1;

    // A release seen while the counter is already full is spurious; drop it.
    assign w_add_inc = add_free && (r_add_cred != ACW'(ADD_RS));
    assign w_mul_inc = mul_free && (r_mul_cred != MCW'(MUL_RS));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_add_cred         <= ACW'(ADD_RS);
            r_mul_cred         <= MCW'(MUL_RS);
            add_issue_valid    <= 1'b0;
            mul_issue_valid    <= 1'b0;
            select_instruction <= 2'b00;
            {add_issue_type, add_issue_dest, add_issue_src1, add_issue_src2} <= '0;
            {mul_issue_type, mul_issue_dest, mul_issue_src1, mul_issue_src2} <= '0;
        end else begin
            r_add_cred         <= r_add_cred - ACW'(w_add_iss) + ACW'(w_add_inc);
            r_mul_cred         <= r_mul_cred - MCW'(w_mul_iss) + MCW'(w_mul_inc);
            add_issue_valid    <= w_add_iss;
            mul_issue_valid    <= w_mul_iss;
            select_instruction <= {w_go1, w_go0};
            // Payloads hold their last value between pulses.
            if (w_add_iss) begin
                {add_issue_type, add_issue_dest, add_issue_src1, add_issue_src2} <= w_add_rec;
            end
            if (w_mul_iss) begin
                {mul_issue_type, mul_issue_dest, mul_issue_src1, mul_issue_src2} <= w_mul_rec;
            end
        end
    end

`ifdef ISSUE_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
            issued_count <= '0;
        end else begin
            if ((w_count != '0) && !w_go0 && (stall_cycles != 16'hFFFF)) begin
                stall_cycles <= stall_cycles + 16'd1;
            end
            issued_count <= issued_count + 16'(w_add_iss) + 16'(w_mul_iss);
        end
    end
`endif

endmodule
